bht_gshare: RTL

- Parametrised successor to the fixed 32-entry, 3-bit-history BHT selected by the core configuration.
- Gshare conditional-branch predictor: PC bits XOR global history register (GHR) index a table of saturating counters.
- Adds speculative GHR update, mispredict GHR restore, and a sequenced table flush.
- Sits in the frontend next to the RAS. Lookup is from the fetch stage; update is from the branch unit at resolve.

---
 rtl/bht_gshare.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bht_gshare.sv
// Gshare branch history table: PC slice XOR global history indexes saturating
// counters, with speculative/restored history and a sequenced table flush.
module bht_gshare #(
  parameter int unsigned VLEN      = 32,
  parameter int unsigned NrEntries = 32,
  parameter int unsigned HistLen   = 3,
  parameter int unsigned CtrWidth  = 2,
  parameter bit          RVC       = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  output logic               busy_o,
  input  logic               lookup_valid_i,
  input  logic [VLEN-1:0]    lookup_pc_i,
  output logic               lookup_taken_o,
  output logic [HistLen-1:0] lookup_ghr_o,
  input  logic               spec_valid_i,
  input  logic               spec_taken_i,
  input  logic               update_valid_i,
  input  logic [VLEN-1:0]    update_pc_i,
  input  logic [HistLen-1:0] update_ghr_i,
  input  logic               update_taken_i,
  input  logic               update_mispredict_i
);

  localparam int unsigned IdxBits = $clog2(NrEntries);
  localparam int unsigned PcLsb   = RVC ? 1 : 2;
  localparam logic [CtrWidth-1:0] CtrInit = CtrWidth'((1 << (CtrWidth - 1)) - 1);
  localparam logic [CtrWidth-1:0] CtrMax  = '1;
  localparam logic [IdxBits-1:0]  LastIdx = IdxBits'(NrEntries - 1);

  if (NrEntries < 2 || (1 << IdxBits) != NrEntries) begin : g_badEntries
    $error("bht_gshare: NrEntries must be a power of 2 and >= 2");
  end
  if (HistLen < 1 || HistLen > IdxBits) begin : g_badHist
    $error("bht_gshare: HistLen must be in 1..IdxBits");
  end
  if (CtrWidth < 2 || CtrWidth > 4) begin : g_badCtr
    $error("bht_gshare: CtrWidth must be in 2..4");
  end
  if (PcLsb + IdxBits > VLEN) begin : g_badVlen
    $error("bht_gshare: VLEN too narrow for the index slice");
  end

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e              r_state, w_stateNext;
  logic [IdxBits-1:0]  r_ptr, w_ptrNext;
  logic [HistLen-1:0]  r_ghr, w_ghrNext, w_restoreGhr, w_specGhr;
  logic [CtrWidth-1:0] r_table [NrEntries];
  logic                w_busy, w_sweepEn, w_flushStart, w_updEn;
  logic [IdxBits-1:0]  w_lookupIdx, w_updateIdx;
  logic [CtrWidth-1:0] w_lookupCtr, w_updCtr, w_updNext;
  logic                w_unusedBits;

  assign w_unusedBits = ^{lookup_pc_i, update_pc_i};

  assign w_lookupIdx = lookup_pc_i[PcLsb +: IdxBits] ^ IdxBits'(r_ghr);
  assign w_updateIdx = update_pc_i[PcLsb +: IdxBits] ^ IdxBits'(update_ghr_i);
  assign w_lookupCtr = r_table[w_lookupIdx];
  assign w_updCtr    = r_table[w_updateIdx];

  always_comb begin
    w_stateNext = r_state;
    w_ptrNext   = r_ptr;
    w_busy      = 1'b0;
    w_sweepEn   = 1'b0;
    case (r_state)
      IDLE: begin
        if (flush_i) begin
          w_stateNext = SWEEP;
          w_ptrNext   = '0;
        end
      end
      SWEEP: begin
        w_busy    = 1'b1;
        w_sweepEn = 1'b1;
        w_ptrNext = r_ptr + 1'b1;
        if (r_ptr == LastIdx) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_ptr   <= w_ptrNext;
    end
  end

  // A flush in IDLE swallows any update arriving in the same cycle.
  assign w_flushStart = (r_state == IDLE) && flush_i;
  assign w_updEn      = update_valid_i && !w_busy && !flush_i;

  if (HistLen == 1) begin : g_hist1
    assign w_restoreGhr = update_taken_i;
    assign w_specGhr    = spec_taken_i;
  end else begin : g_histN
    assign w_restoreGhr = {update_ghr_i[HistLen-2:0], update_taken_i};
    assign w_specGhr    = {r_ghr[HistLen-2:0], spec_taken_i};
  end

  always_comb begin
    w_ghrNext = r_ghr;
    if (w_flushStart || w_busy) begin
      w_ghrNext = '0;
    end else if (update_valid_i && update_mispredict_i) begin
      w_ghrNext = w_restoreGhr;
    end else if (spec_valid_i) begin
      w_ghrNext = w_specGhr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ghr <= '0;
    else         r_ghr <= w_ghrNext;
  end

  always_comb begin
    w_updNext = w_updCtr;
    if (update_taken_i) begin
      if (w_updCtr != CtrMax) w_updNext = w_updCtr + 1'b1;
    end else begin
      if (w_updCtr != '0) w_updNext = w_updCtr - 1'b1;
    end
  end

  // Sweep and update never collide: updates are suppressed while busy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrEntries; i++) r_table[i] <= CtrInit;
    end else if (w_sweepEn) begin
      r_table[r_ptr] <= CtrInit;
    end else if (w_updEn) begin
      r_table[w_updateIdx] <= w_updNext;
    end
  end

  assign busy_o         = w_busy;
  assign lookup_taken_o = lookup_valid_i && !w_busy && w_lookupCtr[CtrWidth-1];
  assign lookup_ghr_o   = r_ghr;

endmodule
